// File: rtl/issue_queue_ctrl.sv
// issue_queue_ctrl: 8-entry show-ahead instruction queue between fetch and
// decode, with dual-issue pairing, hazard/branch/priv slave holding and
// branch delay-slot tracking.
module issue_queue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        F_inst_ok1,
  input  logic        F_inst_ok2,
  input  logic [31:0] F_addr1,
  input  logic [31:0] F_addr2,
  input  logic [31:0] F_data1,
  input  logic [31:0] F_data2,
  output logic        fifo_full_o,
  input  logic        D_stall,
  input  logic        m_is_branch,
  input  logic        m_wr_en,
  input  logic [4:0]  m_dst,
  input  logic        s_is_branch,
  input  logic        s_is_priv,
  input  logic [4:0]  s_src1,
  input  logic [4:0]  s_src2,
  output logic        D_inst_ok1,
  output logic        D_inst_ok2,
  output logic [31:0] D_data1,
  output logic [31:0] D_data2,
  output logic [31:0] D_addr1,
  output logic [31:0] D_addr2,
  output logic        D_ena1,
  output logic        D_en2,
  output logic        master_is_in_delayslot_o
);

  logic [31:0] addr_mem_q [8];
  logic [31:0] data_mem_q [8];

  logic [2:0]  rptr_q, rptr_d;
  logic [2:0]  wptr_q, wptr_d;
  logic [3:0]  count_q, count_d;
  logic        dslot_q, dslot_d;
  logic [63:0] issue_single_cnt;
  logic [63:0] issue_dual_cnt;

  logic        wr1, wr2;
  logic        raw_hazard;
  logic [2:0]  rptr_p1;
  logic [2:0]  wptr_p1;

  assign rptr_p1 = rptr_q + 3'd1;
  assign wptr_p1 = wptr_q + 3'd1;

  // Fetch write enables: blocked when fewer than two slots are free or on flush
  always_comb begin
    fifo_full_o = (count_q > 4'd6);
    wr1         = F_inst_ok1 & ~fifo_full_o & ~flush;
    wr2         = wr1 & F_inst_ok2;
  end

  // Show-ahead head/head+1 outputs and issue decisions
  always_comb begin
    D_inst_ok1 = (count_q >= 4'd1);
    D_inst_ok2 = (count_q >= 4'd2);
    D_addr1    = D_inst_ok1 ? addr_mem_q[rptr_q]  : '0;
    D_data1    = D_inst_ok1 ? data_mem_q[rptr_q]  : '0;
    D_addr2    = D_inst_ok2 ? addr_mem_q[rptr_p1] : '0;
    D_data2    = D_inst_ok2 ? data_mem_q[rptr_p1] : '0;
    raw_hazard = m_wr_en & (m_dst != 5'd0) & ((m_dst == s_src1) | (m_dst == s_src2));
    D_ena1     = D_inst_ok1 & ~D_stall & ~flush;
    // Branch/priv slaves are held back so they lead the next issue group
    D_en2      = D_ena1 & D_inst_ok2 & ~s_is_branch & ~s_is_priv & ~raw_hazard;
    master_is_in_delayslot_o = dslot_q;
  end

  // Next-state pointers, occupancy and delay-slot flag
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    dslot_d = dslot_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      dslot_d = 1'b0;
    end else begin
      rptr_d  = rptr_q + {2'b00, D_ena1} + {2'b00, D_en2};
      wptr_d  = wptr_q + {2'b00, wr1} + {2'b00, wr2};
      // Writes only occur at count<=6 and reads never exceed count, so 0..8 holds
      count_d = count_q + {3'b000, wr1} + {3'b000, wr2}
                        - {3'b000, D_ena1} - {3'b000, D_en2};
      if (D_ena1) dslot_d = m_is_branch & ~D_en2;
    end
  end

  // State register; reset overrides flush
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      dslot_q <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      dslot_q <= dslot_d;
    end
  end

  // Entry storage, unreset; validity is carried by count
  always_ff @(posedge clk) begin
    if (wr1) begin
      addr_mem_q[wptr_q] <= F_addr1;
      data_mem_q[wptr_q] <= F_data1;
    end
    if (wr2) begin
      addr_mem_q[wptr_p1] <= F_addr2;
      data_mem_q[wptr_p1] <= F_data2;
    end
  end

  // Single/dual issue statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_single_cnt <= '0;
      issue_dual_cnt   <= '0;
    end else if (D_en2) begin
      issue_dual_cnt   <= issue_dual_cnt + 64'd1;
    end else if (D_ena1) begin
      issue_single_cnt <= issue_single_cnt + 64'd1;
    end
  end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Directed bench for issue_queue_ctrl: fill/full, pairing, hazards,
// branch holding, pointer wrap, flush and reset priority.
module tb_issue_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        F_inst_ok1, F_inst_ok2;
  logic [31:0] F_addr1, F_addr2, F_data1, F_data2;
  logic        fifo_full_o;
  logic        D_stall;
  logic        m_is_branch, m_wr_en;
  logic [4:0]  m_dst;
  logic        s_is_branch, s_is_priv;
  logic [4:0]  s_src1, s_src2;
  logic        D_inst_ok1, D_inst_ok2;
  logic [31:0] D_data1, D_data2, D_addr1, D_addr2;
  logic        D_ena1, D_en2;
  logic        master_is_in_delayslot_o;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  issue_queue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .F_inst_ok1(F_inst_ok1), .F_inst_ok2(F_inst_ok2),
    .F_addr1(F_addr1), .F_addr2(F_addr2), .F_data1(F_data1), .F_data2(F_data2),
    .fifo_full_o(fifo_full_o), .D_stall(D_stall),
    .m_is_branch(m_is_branch), .m_wr_en(m_wr_en), .m_dst(m_dst),
    .s_is_branch(s_is_branch), .s_is_priv(s_is_priv), .s_src1(s_src1), .s_src2(s_src2),
    .D_inst_ok1(D_inst_ok1), .D_inst_ok2(D_inst_ok2),
    .D_data1(D_data1), .D_data2(D_data2), .D_addr1(D_addr1), .D_addr2(D_addr2),
    .D_ena1(D_ena1), .D_en2(D_en2),
    .master_is_in_delayslot_o(master_is_in_delayslot_o)
  );

  function automatic logic [31:0] A(input int k);
    return 32'hBFC0_0000 + 32'(4 * k);
  endfunction

  function automatic logic [31:0] D(input int k);
    return 32'h1000_0000 + 32'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic ok1, input logic ok2, input int k);
    F_inst_ok1 = ok1;
    F_inst_ok2 = ok2;
    F_addr1 = A(k);
    F_data1 = D(k);
    F_addr2 = A(k + 1);
    F_data2 = D(k + 1);
  endtask

  task automatic hints_clear();
    m_is_branch = 0; m_wr_en = 0; m_dst = 0;
    s_is_branch = 0; s_is_priv = 0; s_src1 = 0; s_src2 = 0;
  endtask

  initial begin
    rst = 1; flush = 0; D_stall = 0;
    fetch(0, 0, 0);
    hints_clear();
    tick(); tick();
    rst = 0;
    #1;
    // reset state
    chk("rst_full", fifo_full_o, 0);
    chk("rst_ok1", D_inst_ok1, 0);
    chk("rst_ok2", D_inst_ok2, 0);
    chk("rst_ena1", D_ena1, 0);
    chk("rst_en2", D_en2, 0);
    chk("rst_data1", D_data1, 0);
    chk("rst_addr1", D_addr1, 0);
    chk("rst_dslot", master_is_in_delayslot_o, 0);

    // fill with decode stalled
    D_stall = 1;
    fetch(1, 1, 0); tick();
    chk("fill_cnt2", dut.count_q, 2);
    chk("fill_ena1_stall", D_ena1, 0);
    chk("fill_addr1", D_addr1, A(0));
    chk("fill_addr2", D_addr2, A(1));
    fetch(1, 1, 2); tick();
    chk("fill_cnt4", dut.count_q, 4);
    fetch(1, 1, 4); tick();
    chk("fill_cnt6", dut.count_q, 6);
    chk("fill_full6", fifo_full_o, 0);
    fetch(1, 1, 6); tick();
    chk("fill_cnt8", dut.count_q, 8);
    chk("fill_full8", fifo_full_o, 1);
    fetch(1, 1, 8); tick();
    chk("drop_cnt8", dut.count_q, 8);
    chk("drop_data1", D_data1, D(0));

    // dual issue
    fetch(0, 0, 0);
    D_stall = 0;
    #1;
    chk("dual_ena1", D_ena1, 1);
    chk("dual_en2", D_en2, 1);
    chk("dual_addr1", D_addr1, 32'hBFC0_0000);
    chk("dual_addr2", D_addr2, 32'hBFC0_0004);
    tick();
    chk("dual_cnt", dut.count_q, 6);
    chk("dual_head", D_addr1, A(2));
    chk("dual_full", fifo_full_o, 0);

    // RAW hazard
    m_wr_en = 1; m_dst = 8; s_src1 = 8; #1;
    chk("raw_ena1", D_ena1, 1);
    chk("raw_en2", D_en2, 0);
    m_dst = 0; #1;
    chk("raw_r0_en2", D_en2, 1);
    m_dst = 5; s_src1 = 0; s_src2 = 5; #1;
    chk("raw_src2_en2", D_en2, 0);
    m_wr_en = 0; #1;
    chk("raw_nowr_en2", D_en2, 1);
    m_wr_en = 1; m_dst = 8; s_src1 = 8; s_src2 = 0;
    tick();
    chk("raw_cnt", dut.count_q, 5);
    chk("raw_head", D_addr1, A(3));
    chk("raw_dslot", master_is_in_delayslot_o, 0);

    // branch slave held, then branch master paired with its delay slot
    hints_clear();
    s_is_branch = 1; #1;
    chk("brs_ena1", D_ena1, 1);
    chk("brs_en2", D_en2, 0);
    tick();
    chk("brs_cnt", dut.count_q, 4);
    chk("brs_head", D_addr1, A(4));
    s_is_branch = 0; m_is_branch = 1; #1;
    chk("brm_en2", D_en2, 1);
    tick();
    chk("brm_cnt", dut.count_q, 2);
    chk("brm_dslot", master_is_in_delayslot_o, 0);
    chk("brm_head", D_addr1, A(6));
    m_is_branch = 0; s_is_priv = 1; #1;
    chk("priv_en2", D_en2, 0);
    tick();
    chk("priv_cnt", dut.count_q, 1);
    chk("priv_ok2", D_inst_ok2, 0);
    s_is_priv = 0; m_is_branch = 1; #1;
    chk("lone_ena1", D_ena1, 1);
    chk("lone_en2", D_en2, 0);
    tick();
    chk("lone_dslot", master_is_in_delayslot_o, 1);
    chk("lone_ok1", D_inst_ok1, 0);
    tick();
    chk("idle_dslot_hold", master_is_in_delayslot_o, 1);
    m_is_branch = 0;

    // pointer wrap with concurrent dual issue
    D_stall = 1;
    fetch(1, 1, 16); tick();
    fetch(1, 1, 18); tick();
    fetch(1, 1, 20); tick();
    chk("wrap_cnt6", dut.count_q, 6);
    chk("wrap_wptr6", dut.wptr_q, 6);
    fetch(0, 0, 0); D_stall = 0; tick();
    chk("wrap_cnt4", dut.count_q, 4);
    chk("wrap_head", D_addr1, A(18));
    fetch(1, 0, 22); D_stall = 1; tick();
    chk("wrap_wptr7", dut.wptr_q, 7);
    fetch(1, 1, 23); D_stall = 0; #1;
    chk("wrap_en2", D_en2, 1);
    tick();
    chk("wrap_cnt_const", dut.count_q, 5);
    chk("wrap_wptr1", dut.wptr_q, 1);
    fetch(0, 0, 0); tick();
    chk("wrap_e7_addr", D_addr2, A(23));
    tick();
    chk("wrap_e0_addr", D_addr1, A(24));
    chk("wrap_e0_data", D_data1, D(24));
    chk("wrap_inv_data2", D_data2, 0);
    chk("wrap_inv_addr2", D_addr2, 0);

    // flush with 5 queued and a fetch pair present
    m_is_branch = 1; tick();
    chk("pre_fl_dslot", master_is_in_delayslot_o, 1);
    m_is_branch = 0; D_stall = 1;
    fetch(1, 1, 30); tick();
    fetch(1, 1, 32); tick();
    fetch(1, 0, 34); tick();
    chk("pre_fl_cnt", dut.count_q, 5);
    fetch(1, 1, 40); D_stall = 0; flush = 1; #1;
    chk("fl_ena1", D_ena1, 0);
    chk("fl_en2", D_en2, 0);
    tick();
    flush = 0; fetch(0, 0, 0); #1;
    chk("fl_cnt", dut.count_q, 0);
    chk("fl_ok1", D_inst_ok1, 0);
    chk("fl_dslot", master_is_in_delayslot_o, 0);
    chk("fl_wptr", dut.wptr_q, 0);
    chk("fl_rptr", dut.rptr_q, 0);
    chk("stat_single", dut.issue_single_cnt, 5);
    chk("stat_dual", dut.issue_dual_cnt, 6);

    // reset beats flush mid-operation
    D_stall = 1;
    fetch(1, 1, 50); tick();
    fetch(1, 1, 52); tick();
    chk("pre_rst_cnt", dut.count_q, 4);
    rst = 1; flush = 1; fetch(1, 1, 54); tick();
    rst = 0; flush = 0; fetch(0, 0, 0); #1;
    chk("mrst_cnt", dut.count_q, 0);
    chk("mrst_ok1", D_inst_ok1, 0);
    chk("mrst_wptr", dut.wptr_q, 0);
    chk("mrst_single", dut.issue_single_cnt, 0);
    chk("mrst_dual", dut.issue_dual_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/issue_queue_ctrl.md
ISSUE_QUEUE_CTRL -- requirements
Module: issue_queue_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-002 SHALL have flush in 1: discard all queued instructions.
REQ-003 SHALL have F_inst_ok1/F_inst_ok2 in 1 each, F_addr1/F_addr2 in 32, F_data1/F_data2 in 32: fetch pair; ok2 only meaningful with ok1.
REQ-004 SHALL have fifo_full_o out 1: fetch must hold, fewer than 2 free slots.
REQ-005 SHALL have D_stall in 1: decode/issue stage cannot accept this cycle.
REQ-006 SHALL have decoder hints in: m_is_branch 1, m_wr_en 1, m_dst 5 (head entry); s_is_branch 1, s_is_priv 1, s_src1 5, s_src2 5 (head+1 entry).
REQ-007 SHALL have D_inst_ok1/D_inst_ok2 out 1, D_data1/D_data2 out 32, D_addr1/D_addr2 out 32: head and head+1 entries (show-ahead).
REQ-008 SHALL have D_ena1/D_en2 out 1: master/slave issued this cycle; master_is_in_delayslot_o out 1.

Function
REQ-009 SHALL implement an 8-entry circular queue of {addr,data}; 3-bit rptr/wptr wrap 7->0; 4-bit count 0..8.
REQ-010 SHALL assert fifo_full_o combinationally when count > 6.
REQ-011 SHALL write on posedge when !fifo_full_o: ok1 -> entry[wptr]; ok1&ok2 -> also entry[wptr+1]; wptr += writes (mod 8); ok2 without ok1 ignored.
REQ-012 SHALL ignore fetch writes while fifo_full_o=1 (no overwrite, no count change).
REQ-013 SHALL drive D_inst_ok1 = (count>=1), D_inst_ok2 = (count>=2); D_data/D_addr of invalid slot = 0.
REQ-014 SHALL drive D_ena1 = D_inst_ok1 & !D_stall & !flush.
REQ-015 SHALL drive D_en2 = D_ena1 & D_inst_ok2 & !s_is_branch & !s_is_priv & !(m_wr_en & m_dst!=0 & (m_dst==s_src1 | m_dst==s_src2)).
REQ-016 SHALL permit branch master with its delay slot as slave in the same cycle (pairing preferred).
REQ-017 SHALL hold a branch or privileged slave so it becomes next cycle's master.
REQ-018 SHALL advance rptr by D_ena1+D_en2 and set count <= count + writes - reads in one cycle; simultaneous read/write at full/empty boundaries exact, never over/underflow.
REQ-019 SHALL set master_is_in_delayslot_o <= 1 when D_ena1 & m_is_branch & !D_en2; <= 0 when D_ena1 otherwise; hold when !D_ena1.
REQ-020 SHALL, on flush, next cycle set rptr=wptr=0, count=0, master_is_in_delayslot_o=0, ignore same-cycle fetch writes; D_ena1/D_en2=0 during flush cycle.
REQ-021 SHALL treat rst higher priority than flush; rst mid-operation discards all entries.
REQ-022 SHALL keep 64-bit counters issue_single_cnt/issue_dual_cnt (reset 0) for dual-issue rate statistics; not ports.

Reset
REQ-023 SHALL, while rst=1 at posedge, clear rptr, wptr, count, master_is_in_delayslot_o, statistic counters.
REQ-024 SHALL, after reset, output fifo_full_o=0, D_inst_ok1/2=0, D_ena1/D_en2=0, D_data/D_addr=0.
REQ-025 SHALL not require entry storage to be reset.

Verification
REQ-026 Fill: 4 cycles ok1=ok2=1, D_stall=1 -> count 2,4,6,8; fifo_full_o=1 after count 8 (at 7 too); 5th pair dropped, count stays 8.
REQ-027 Dual issue: queue {0xBFC00000,0xBFC00004}, no hazard, D_stall=0 -> D_ena1=D_en2=1, rptr+2, count-2.
REQ-028 RAW: m_wr_en=1,m_dst=8,s_src1=8 -> D_ena1=1,D_en2=0; m_dst=0 same case -> D_en2=1.
REQ-029 Branch: slave s_is_branch=1 -> D_en2=0; next cycle branch as master with m_is_branch=1, slave valid -> both issue, delayslot flag 0; queue with only branch -> single issue, delayslot flag 1 next cycle.
REQ-030 Wrap: wptr=7, write pair -> entries 7,0 written, wptr=1; concurrent dual issue keeps count constant.
REQ-031 Flush with count=5 and fetch pair present -> next cycle count=0, D_inst_ok1=0, delayslot flag 0.
